// File: rtl/freq_regulator_param_if.sv
// Bus bundle for freq_regulator_param.
// The master drives the regulator controls and the pulse input; the slave
// (the regulator) returns the divider value, the adjustment direction, the
// measurement and the status flags.
//   en, psi, mode                 : enable, pulse input, measurement mode
//   set_period, tolerance         : target measurement and allowed |error|
//   step_shift                    : 0xF = unit step, else |error| >> step_shift
//   adjusted_div, adj_dir         : divider value and last adjustment direction
//   meas, meas_valid, overflow    : last measurement, update strobe, saturation
//   locked                        : regulator in lock
interface freq_regulator_param_if #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 8
);
    logic             en;
    logic             psi;
    logic             mode;
    logic [CNT_W-1:0] set_period;
    logic [CNT_W-1:0] tolerance;
    logic [3:0]       step_shift;
    logic [DIV_W-1:0] adjusted_div;
    logic [1:0]       adj_dir;
    logic [CNT_W-1:0] meas;
    logic             meas_valid;
    logic             overflow;
    logic             locked;

    modport master (
        output en, psi, mode, set_period, tolerance, step_shift,
        input  adjusted_div, adj_dir, meas, meas_valid, overflow, locked
    );

    modport slave (
        input  en, psi, mode, set_period, tolerance, step_shift,
        output adjusted_div, adj_dir, meas, meas_valid, overflow, locked
    );
endinterface

// File: rtl/freq_regulator_param.sv
// Closed-loop frequency regulator.
// Measures the high time (mode 0) or rising-to-rising period (mode 1) of psi
// in clk cycles, compares the measurement against set_period with a tolerance
// band and steps a saturating divider value up or down by a unit or
// proportional step. Lock is declared after LOCK_N consecutive in-band
// measurements.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : freq_regulator_param_if slave modport (controls, psi, results)
module freq_regulator_param #(
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 127,
    parameter int DIV_MIN  = 1,
    parameter int DIV_MAX  = 255,
    parameter int MAX_STEP = 16,
    parameter int LOCK_N   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    freq_regulator_param_if.slave bus
);

    localparam int LOCK_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  MAX_STEP_C = CNT_W'(MAX_STEP);
    localparam logic [DIV_W:0]    DIV_MIN_X  = (DIV_W + 1)'(DIV_MIN);
    localparam logic [DIV_W:0]    DIV_MAX_X  = (DIV_W + 1)'(DIV_MAX);
    localparam logic [DIV_W-1:0]  DIV_INIT_C = DIV_W'(DIV_INIT);
    localparam logic [LOCK_W-1:0] LOCK_N_C   = LOCK_W'(LOCK_N);
    localparam logic [LOCK_W-1:0] LOCK_ONE   = LOCK_W'(1);

    localparam logic [1:0] DIR_UP   = 2'b11;
    localparam logic [1:0] DIR_DOWN = 2'b00;
    localparam logic [1:0] DIR_HOLD = 2'b10;

    logic              psi_q, psi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  meas_q, meas_d;
    logic              meas_valid_q, meas_valid_d;
    logic              ovf_q, ovf_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        adj_dir_q, adj_dir_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

    logic             rise, fall;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;

    logic             eval;
    logic [CNT_W-1:0] err;
    logic             in_band;
    logic             go_up;
    logic [CNT_W-1:0] shifted;
    logic [CNT_W-1:0] step_raw;
    logic [CNT_W-1:0] step;
    logic [DIV_W:0]   step_x;
    logic [DIV_W:0]   sum;
    logic [DIV_W:0]   diff;

    // ------------------------------------------------------------------
    // Edge detection and measurement
    // ------------------------------------------------------------------
    always_comb begin
        rise    = bus.psi & ~psi_q;
        fall    = ~bus.psi & psi_q;
        cnt_sat = (cnt_q == CNT_MAX);
        // Saturating increment; doubles as the saturated measurement value.
        cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

        psi_d        = bus.psi;
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        meas_d       = meas_q;
        meas_valid_d = 1'b0;
        ovf_d        = 1'b0;

        if (!bus.en) begin
            // Also swallows any edge that coincides with en falling.
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (!bus.mode) begin
            if (rise) begin
                cnt_d   = '0;
                armed_d = 1'b1;
            end else if (psi_q && bus.psi) begin
                cnt_d = cnt_inc;
            end
            // A pulse already high when en rose is never armed, so its
            // truncated high time is not reported.
            if (fall && armed_q) begin
                meas_d       = cnt_inc;
                meas_valid_d = 1'b1;
                ovf_d        = cnt_sat;
            end
        end else begin
            cnt_d = cnt_inc;
            if (rise) begin
                cnt_d = '0;
                if (armed_q) begin
                    meas_d       = cnt_inc;
                    meas_valid_d = 1'b1;
                    ovf_d        = cnt_sat;
                end else begin
                    armed_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Evaluation, one cycle after meas_valid
    // ------------------------------------------------------------------
    always_comb begin
        eval    = meas_valid_q & bus.en;
        err     = (meas_q > bus.set_period) ? (meas_q - bus.set_period)
                                            : (bus.set_period - meas_q);
        in_band = !ovf_q && (err <= bus.tolerance);
        go_up   = ovf_q || (meas_q > bus.set_period);
        shifted = err >> bus.step_shift;

        if (bus.step_shift == 4'hF) begin
            step_raw = CNT_ONE;
        end else if (shifted == '0) begin
            step_raw = CNT_ONE;
        end else begin
            step_raw = shifted;
        end
        step   = (step_raw > MAX_STEP_C) ? MAX_STEP_C : step_raw;
        step_x = (DIV_W + 1)'(step);

        // One extra bit catches carry past DIV_MAX and borrow below zero.
        sum  = {1'b0, div_q} + step_x;
        diff = {1'b0, div_q} - step_x;

        div_d      = div_q;
        adj_dir_d  = DIR_HOLD;
        lock_cnt_d = lock_cnt_q;

        if (!bus.en) begin
            lock_cnt_d = '0;
        end else if (eval) begin
            if (in_band) begin
                if (lock_cnt_q != LOCK_N_C) begin
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end
            end else begin
                lock_cnt_d = '0;
                if (go_up) begin
                    adj_dir_d = DIR_UP;
                    div_d     = (sum > DIV_MAX_X) ? DIV_MAX_X[DIV_W-1:0] : sum[DIV_W-1:0];
                end else begin
                    adj_dir_d = DIR_DOWN;
                    div_d     = (diff[DIV_W] || (diff < DIV_MIN_X)) ? DIV_MIN_X[DIV_W-1:0]
                                                                     : diff[DIV_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psi_q        <= 1'b0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            meas_q       <= '0;
            meas_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            div_q        <= DIV_INIT_C;
            adj_dir_q    <= DIR_HOLD;
            lock_cnt_q   <= '0;
        end else begin
            psi_q        <= psi_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            ovf_q        <= ovf_d;
            div_q        <= div_d;
            adj_dir_q    <= adj_dir_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign bus.adjusted_div = div_q;
    assign bus.adj_dir      = adj_dir_q;
    assign bus.meas         = meas_q;
    assign bus.meas_valid   = meas_valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.locked       = (lock_cnt_q == LOCK_N_C);

endmodule

// File: tb/tb_freq_regulator_param.sv
// Self-checking bench for freq_regulator_param (CNT_W=8 so that counter
// saturation is reachable in a short run). Expected values come from a
// behavioural model that works on whole pulse lengths and periods.
module tb_freq_regulator_param;

    localparam int CNT_W    = 8;
    localparam int DIV_W    = 8;
    localparam int CNT_MAX  = 255;
    localparam int DIV_INIT = 127;
    localparam int DIV_MIN  = 1;
    localparam int DIV_MAX  = 255;
    localparam int MAX_STEP = 16;
    localparam int LOCK_N   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_regulator_param_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) bus ();

    freq_regulator_param #(
        .CNT_W(CNT_W), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT), .DIV_MIN(DIV_MIN),
        .DIV_MAX(DIV_MAX), .MAX_STEP(MAX_STEP), .LOCK_N(LOCK_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_div   = DIV_INIT;
    int m_lock  = 0;
    int m_dir   = 2;
    bit m_armed = 1'b0;   // mode 1: a first rise has been seen since enable
    int last_p  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the regulation rules to one measurement.
    task automatic model_eval(input int meas, input bit ovf);
        int err, step;
        err = (meas > int'(bus.set_period)) ? meas - int'(bus.set_period)
                                            : int'(bus.set_period) - meas;
        if (!ovf && err <= int'(bus.tolerance)) begin
            m_dir  = 2;
            m_lock = (m_lock < LOCK_N) ? m_lock + 1 : LOCK_N;
        end else begin
            m_lock = 0;
            if (bus.step_shift == 4'hF) step = 1;
            else step = err >> bus.step_shift;
            if (step < 1) step = 1;
            if (step > MAX_STEP) step = MAX_STEP;
            if (ovf || meas > int'(bus.set_period)) begin
                m_dir = 3;
                m_div = (m_div + step > DIV_MAX) ? DIV_MAX : m_div + step;
            end else begin
                m_dir = 0;
                m_div = (m_div - step < DIV_MIN) ? DIV_MIN : m_div - step;
            end
        end
    endtask

    task automatic check_meas(input int len);
        int  em;
        bit  eo;
        em = (len > CNT_MAX) ? CNT_MAX : len;
        eo = (len > CNT_MAX);
        check_eq("meas_valid", bus.meas_valid, 1);
        check_eq("meas", bus.meas, em);
        check_eq("overflow", bus.overflow, eo);
        model_eval(em, eo);
    endtask

    // Called one tick after the event edge; consumes E+1 and E+2.
    task automatic check_result();
        tick();
        check_eq("adj_dir", bus.adj_dir, m_dir);
        check_eq("adjusted_div", bus.adjusted_div, m_div);
        check_eq("locked", bus.locked, (m_lock == LOCK_N));
        check_eq("valid_pulse", bus.meas_valid, 0);
        tick();
        check_eq("adj_dir_back", bus.adj_dir, 2);
    endtask

    // Mode 0: high for h cycles, then low for l (>=3) cycles.
    task automatic pulse0(input int h, input int l);
        bus.psi = 1'b1;
        repeat (h) tick();
        bus.psi = 1'b0;
        tick();
        check_meas(h);
        check_result();
        repeat (l - 3) tick();
    endtask

    // Mode 1: one rise, then a period of p (>=3) cycles until the next call.
    task automatic per1(input int p);
        int done;
        bus.psi = 1'b1;
        tick();
        bus.psi = 1'b0;
        done = 0;
        if (m_armed) begin
            check_meas(last_p);
            check_result();
            done = 2;
        end else begin
            check_eq("first_rise_novalid", bus.meas_valid, 0);
            tick();
            done = 1;
        end
        m_armed = 1'b1;
        repeat (p - 1 - done) tick();
        last_p = p;
    endtask

    task automatic set_mode(input bit md);
        bus.en = 1'b0;
        tick();
        m_lock  = 0;
        m_armed = 1'b0;
        bus.mode = md;
        bus.en = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_div"}, bus.adjusted_div, DIV_INIT);
        check_eq({tag, "_dir"}, bus.adj_dir, 2);
        check_eq({tag, "_meas"}, bus.meas, 0);
        check_eq({tag, "_valid"}, bus.meas_valid, 0);
        check_eq({tag, "_ovf"}, bus.overflow, 0);
        check_eq({tag, "_locked"}, bus.locked, 0);
    endtask

    initial begin
        bus.en         = 1'b0;
        bus.psi        = 1'b0;
        bus.mode       = 1'b0;
        bus.set_period = 8'd10;
        bus.tolerance  = 8'd0;
        bus.step_shift = 4'hF;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Mode 0 basics
        bus.en = 1'b1;
        tick();
        pulse0(10, 5);
        check_eq("hold_div", bus.adjusted_div, 127);
        bus.step_shift = 4'd0;
        pulse0(12, 5);
        check_eq("inc_div", bus.adjusted_div, 129);
        pulse0(4, 5);
        check_eq("dec_div", bus.adjusted_div, 123);

        // Mode 1 lock and loss of lock
        bus.set_period = 8'd20;
        bus.tolerance  = 8'd1;
        bus.step_shift = 4'hF;
        set_mode(1'b1);
        repeat (5) per1(21);
        check_eq("locked_after4", bus.locked, 1);
        per1(25);
        per1(21);
        check_eq("unlocked_after25", bus.locked, 0);
        per1(21);

        // Overflow of the 8-bit counter
        bus.set_period = 8'd10;
        bus.tolerance  = 8'd0;
        set_mode(1'b0);
        pulse0(300, 5);

        // Clamp at DIV_MAX with maximum step
        bus.step_shift = 4'd0;
        repeat (10) pulse0(110, 4);
        check_eq("clamp_max", bus.adjusted_div, 255);

        // Reset during the evaluation cycle
        bus.psi = 1'b1;
        repeat (8) tick();
        bus.psi = 1'b0;
        tick();
        check_eq("pre_rst_valid", bus.meas_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1;
        rst = 1'b0;
        m_div = DIV_INIT; m_lock = 0; m_armed = 1'b0;
        repeat (3) tick();
        check_eq("post_rst_div", bus.adjusted_div, DIV_INIT);

        // Drop en mid-pulse
        bus.psi = 1'b1;
        repeat (5) tick();
        bus.en = 1'b0;
        m_lock = 0;
        repeat (3) tick();
        bus.en = 1'b1;
        repeat (3) tick();
        bus.psi = 1'b0;
        tick();
        check_eq("en_drop_novalid", bus.meas_valid, 0);
        tick();
        check_eq("en_drop_div", bus.adjusted_div, m_div);
        check_eq("en_drop_dir", bus.adj_dir, 2);

        // Randomised phase
        for (int it = 0; it < 30; it++) begin
            bus.set_period = 8'($urandom_range(1, 200));
            bus.tolerance  = 8'($urandom_range(0, 10));
            bus.step_shift = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 0) begin
                set_mode(1'b0);
                for (int k = 0; k < 3; k++) begin
                    if ($urandom_range(0, 9) == 0) pulse0($urandom_range(250, 300), $urandom_range(3, 8));
                    else pulse0($urandom_range(1, 60), $urandom_range(3, 8));
                end
            end else begin
                set_mode(1'b1);
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 9) == 0) per1($urandom_range(250, 270));
                    else per1($urandom_range(3, 60));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
